mem_arbiter: RTL and testbench

- Two-requester arbiter for the single synchronous memory port.
- Shares the port between the CPU core and an external requester (program loader / debug DMA).
- Applies round-robin tie-breaking and a bounded burst length so neither side starves.
- Sits between the core's address/write-data outputs and memory. Its CPU stall output is ORed into the core's clock-stretch path.

---
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between the CPU and an
// external requester, with a bounded burst per owner and tagged read-return routing.
module mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic              ext_we,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        OWN_CPU = 2'b01,
        OWN_EXT = 2'b10
    } state_t;

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_t           state, state_nxt;
    logic             last_served;  // 1 = EXT was served last
    logic [CNT_W-1:0] burst_cnt;
    logic             rd_pend;
    logic             rd_tag;       // 1 = pending read belongs to EXT
    logic             burst_done;

    assign cpu_gnt   = (state == OWN_CPU) & cpu_req;
    assign ext_gnt   = (state == OWN_EXT) & ext_req;
    assign cpu_stall = cpu_req & ~cpu_gnt;
    assign owner     = state;

    // Greater-or-equal so a count saturated during an uncontended run still
    // hands over on the first accept after the other side starts requesting.
    assign burst_done = (int'(burst_cnt) + 1) >= MAX_BURST;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            OWN_CPU: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            OWN_EXT: begin
                mem_addr  = ext_addr;
                mem_wdata = ext_wdata;
            end
            default: ;
        endcase
    end

    assign mem_we = (cpu_gnt & cpu_we) | (ext_gnt & ext_we);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cpu_req && ext_req) state_nxt = last_served ? OWN_CPU : OWN_EXT;
                else if (cpu_req)       state_nxt = OWN_CPU;
                else if (ext_req)       state_nxt = OWN_EXT;
            end
            OWN_CPU: begin
                if (!cpu_req)                state_nxt = ext_req ? OWN_EXT : IDLE;
                else if (ext_req && burst_done) state_nxt = OWN_EXT;
            end
            OWN_EXT: begin
                if (!ext_req)                state_nxt = cpu_req ? OWN_CPU : IDLE;
                else if (cpu_req && burst_done) state_nxt = OWN_CPU;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            last_served <= 1'b1;
            burst_cnt   <= '0;
            rd_pend     <= 1'b0;
            rd_tag      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                burst_cnt <= '0;
                if (state != IDLE) last_served <= (state == OWN_EXT);
            end else if ((cpu_gnt || ext_gnt) && burst_cnt != CNT_W'(MAX_BURST)) begin
                burst_cnt <= burst_cnt + CNT_W'(1);
            end
            rd_pend <= (cpu_gnt & ~cpu_we) | (ext_gnt & ~ext_we);
            rd_tag  <= ext_gnt;
        end
    end

    assign cpu_rvalid = rd_pend & ~rd_tag;
    assign ext_rvalid = rd_pend & rd_tag;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign ext_rdata  = ext_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: scenario tasks plus a read-return scoreboard fed on accepts.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, ext_req, ext_we;
    logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
    logic        cpu_gnt, cpu_rvalid, cpu_stall, ext_gnt, ext_rvalid, mem_we;
    logic [31:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [1:0]  owner;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        side;  // 1 = EXT
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_addr(ext_addr), .ext_we(ext_we), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .owner(owner)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Synchronous memory: data for the address presented in one cycle appears in the next.
    always @(posedge clk) mem_rdata <= model(mem_addr);

    always @(posedge clk) if (reset === 1'b0) exp_q.delete();

    // Scoreboard: compare read returns against what was accepted last cycle, then log this cycle's accepts.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (cpu_rvalid !== !e.side || ext_rvalid !== e.side ||
                (e.side ? ext_rdata : cpu_rdata) !== e.data ||
                (e.side ? cpu_rdata : ext_rdata) !== 32'h0) begin
                errors++;
                $display("FAIL rd_return t=%0t got cpu_rv=%b ext_rv=%b cpu_rd=%h ext_rd=%h want side=%b data=%h",
                         $time, cpu_rvalid, ext_rvalid, cpu_rdata, ext_rdata, e.side, e.data);
            end
        end else begin
            checks++;
            if (cpu_rvalid !== 1'b0 || ext_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL spurious_rvalid t=%0t got cpu_rv=%b ext_rv=%b want 0 0", $time, cpu_rvalid, ext_rvalid);
            end
        end
        if (cpu_req === 1'b1 && cpu_gnt === 1'b1 && cpu_we === 1'b0) exp_q.push_back({1'b0, model(cpu_addr)});
        if (ext_req === 1'b1 && ext_gnt === 1'b1 && ext_we === 1'b0) exp_q.push_back({1'b1, model(ext_addr)});
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; cpu_wdata = 32'h0;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h200; ext_wdata = 32'h0;
        repeat (3) step();
        @(negedge clk);
        checks++;
        if (owner !== 2'b00 || cpu_gnt !== 1'b0 || ext_gnt !== 1'b0 || mem_we !== 1'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || cpu_rdata !== 32'h0 || ext_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got owner=%b gnt=%b%b we=%b addr=%h wd=%h want all 0",
                     owner, cpu_gnt, ext_gnt, mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if (cpu_stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall got %b want 1", cpu_stall);
        end
        reset = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (owner !== 2'b01 || cpu_gnt !== 1'b1 || ext_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL first_tie got owner=%b cpu_gnt=%b ext_gnt=%b stall=%b want 01 1 0 0",
                     owner, cpu_gnt, ext_gnt, cpu_stall);
        end
        checks++;
        if (mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL first_addr got %h want 00000100", mem_addr);
        end
        step();
        cpu_req = 1'b0; ext_req = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_single_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b0 || cpu_stall !== 1'b1) begin
            errors++;
            $display("FAIL rd_n got gnt=%b stall=%b want 0 1", cpu_gnt, cpu_stall);
        end
        step();
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL rd_n1 got gnt=%b addr=%h we=%b want 1 00000010 0", cpu_gnt, mem_addr, mem_we);
        end
        step();
        cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || ext_rvalid !== 1'b0 || ext_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rd_n2 got rv=%b rd=%h ext_rv=%b want 1 deadbeef 0", cpu_rvalid, cpu_rdata, ext_rvalid);
        end
        repeat (3) step();
    endtask

    // Last served was CPU, so a tie from IDLE goes to EXT; dropping ext_req hands straight to CPU.
    task automatic test_tie();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h400;
        step();
        @(negedge clk);
        checks++;
        if (owner !== 2'b10 || ext_gnt !== 1'b1 || cpu_stall !== 1'b1 || mem_addr !== 32'h400) begin
            errors++;
            $display("FAIL tie_rr got owner=%b ext_gnt=%b stall=%b addr=%h want 10 1 1 00000400",
                     owner, ext_gnt, cpu_stall, mem_addr);
        end
        step();
        ext_req = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (owner !== 2'b01 || cpu_gnt !== 1'b1) begin
            errors++;
            $display("FAIL tie_handover got owner=%b cpu_gnt=%b want 01 1", owner, cpu_gnt);
        end
        step();
        cpu_req = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_contention();
        logic [1:0] exp_own;
        for (int i = 0; i < 18; i++) begin
            step();
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1000 + 32'(((i < 1) ? 1 : i) * 4);
            ext_req = (i >= 3); ext_we = 1'b0; ext_addr = 32'h2000 + 32'(((i < 9) ? 9 : i) * 4);
            exp_own = (i == 0) ? 2'b00 : (i <= 8) ? 2'b01 : (i <= 16) ? 2'b10 : 2'b01;
            @(negedge clk);
            checks++;
            if (owner !== exp_own || cpu_gnt !== (exp_own == 2'b01) || ext_gnt !== (exp_own == 2'b10)) begin
                errors++;
                $display("FAIL burst_cycle%0d got owner=%b cpu_gnt=%b ext_gnt=%b want owner=%b",
                         i, owner, cpu_gnt, ext_gnt, exp_own);
            end
            if (i == 9) begin
                checks++;
                if (cpu_rvalid !== 1'b1 || cpu_rdata !== model(32'h1020)) begin
                    errors++;
                    $display("FAIL last_cpu_read got rv=%b rd=%h want 1 %h", cpu_rvalid, cpu_rdata, model(32'h1020));
                end
            end
            if (i == 17) begin
                checks++;
                if (ext_rvalid !== 1'b1 || ext_rdata !== model(32'h2040)) begin
                    errors++;
                    $display("FAIL last_ext_read got rv=%b rd=%h want 1 %h", ext_rvalid, ext_rdata, model(32'h2040));
                end
            end
        end
        step();
        cpu_req = 1'b0; ext_req = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_write();
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h20; ext_wdata = 32'h55;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0 || ext_gnt !== 1'b0) begin
            errors++;
            $display("FAIL wr_idle got we=%b gnt=%b want 0 0", mem_we, ext_gnt);
        end
        step();
        @(negedge clk);
        checks++;
        if (owner !== 2'b10 || ext_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'h55) begin
            errors++;
            $display("FAIL wr_accept got owner=%b gnt=%b we=%b addr=%h wd=%h want 10 1 1 00000020 00000055",
                     owner, ext_gnt, mem_we, mem_addr, mem_wdata);
        end
        step();
        ext_req = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0 || owner !== 2'b10) begin
            errors++;
            $display("FAIL wr_once got we=%b owner=%b want 0 10", mem_we, owner);
        end
        step();
        @(negedge clk);
        checks++;
        if (owner !== 2'b00 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL wr_idle_after got owner=%b addr=%h wd=%h want 00 0 0", owner, mem_addr, mem_wdata);
        end
        ext_we = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_reset_pending();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h44;
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rp_accept got gnt=%b want 1", cpu_gnt);
        end
        step();
        cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b0 || ext_rvalid !== 1'b0 || owner !== 2'b00 || cpu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rp_dropped got cpu_rv=%b ext_rv=%b owner=%b want 0 0 00", cpu_rvalid, ext_rvalid, owner);
        end
        step();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_rvalid !== 1'b0 || owner !== 2'b00) begin
            errors++;
            $display("FAIL rp_after got rv=%b owner=%b want 0 00", cpu_rvalid, owner);
        end
        repeat (2) step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_contention();
        test_write();
        test_reset_pending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
